// File: rtl/ifq_pkg.sv
// Shared constants and types for the instruction fetch queue.
package ifq_pkg;

  localparam int XLEN = 32;

  typedef logic [XLEN-1:0] word_t;

  localparam word_t CPU_START_ADDR = 32'h0000_0000;
  localparam word_t INST_NOP       = 32'h0000_0013;  // addi x0, x0, 0
  localparam word_t WORD_BYTES     = 32'h0000_0004;

  // One queue entry: the instruction and the address it was fetched from.
  typedef struct packed {
    word_t pc;
    word_t inst;
  } fetch_entry_t;

  // Clears the byte-offset bits; masking keeps every input bit in use.
  function automatic word_t word_align(input word_t addr);
    return addr & ~word_t'(3);
  endfunction

endpackage

// File: rtl/ifq_if.sv
// Bus bundles around the fetch queue: the instruction-memory port and the
// valid/ready port towards the fetch unit. The queue is master on both.

interface ifq_mem_if;
  logic              req;
  ifq_pkg::word_t    addr;
  logic              gnt;
  logic              rvalid;
  ifq_pkg::word_t    rdata;

  modport master (output req, addr, input gnt, rvalid, rdata);
  modport slave  (input req, addr, output gnt, rvalid, rdata);
endinterface

interface ifq_fetch_if;
  logic              valid;
  ifq_pkg::word_t    inst;
  ifq_pkg::word_t    pc;
  logic              ready;

  modport master (output valid, inst, pc, input ready);
  modport slave  (input valid, inst, pc, output ready);
endinterface

// File: rtl/ifq_fifo.sv
// Circular buffer with wrap-bit pointers. Full/empty and the occupancy count
// all fall out of the pointer pair, so they can never disagree.
module ifq_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clear_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         push_data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         head_data_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign count_o = wr_ptr_q - rd_ptr_q;

  // A push at full is only legal alongside a pop that frees the slot.
  assign do_push = push_i && !clear_i && (!full || pop_i);
  assign do_pop  = pop_i && !clear_i && !empty_o;

  assign head_data_o = mem_q[rd_ptr_q[AW-1:0]];

  // Next pointer values; clear collapses both pointers to zero.
  always_comb begin
    // NOTE: every output gets a default before any branch so no latch is inferred.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (clear_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  // Pointer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Entry storage, written at the tail.
  // NOTE: storage has no reset; a slot is only read after it has been written.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
  end

endmodule

// File: rtl/ifq.sv
// Instruction fetch queue: owns the sequential fetch PC, issues word requests
// under a credit limit, buffers in-order responses and drops the ones that
// were already in flight when a redirect arrived.
module ifq
  import ifq_pkg::*;
#(
  parameter int    DEPTH      = 4,
  parameter int    MAX_OUTST  = 2,
  parameter word_t START_ADDR = CPU_START_ADDR
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush_i,
  input  word_t         flush_addr_i,
  ifq_mem_if.master     mem,
  ifq_fetch_if.master   fetch
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int OW = $clog2(MAX_OUTST + 1);
  localparam int SW = ((CW > OW) ? CW : OW) + 1;

  word_t         fetch_pc_q, fetch_pc_d;
  word_t         resp_pc_q,  resp_pc_d;
  word_t         last_pc_q,  last_pc_d;
  logic [OW-1:0] outst_q,    outst_d;
  logic [OW-1:0] drop_q,     drop_d;

  logic [CW-1:0] count;
  logic          empty;
  logic [SW-1:0] credit_used;
  logic          req_acc;
  logic          keep_rsp;
  logic          push;
  logic          pop;
  fetch_entry_t  push_entry;
  fetch_entry_t  head_entry;

  // Queued entries plus in-flight requests never exceed DEPTH, so every
  // kept response has a free slot waiting for it.
  assign credit_used = SW'(count) + SW'(outst_q);

  // rst_n is folded in so the request drops the instant reset asserts.
  assign mem.req  = rst_n && !flush_i &&
                    (credit_used < SW'(DEPTH)) && (outst_q < OW'(MAX_OUTST));
  assign mem.addr = fetch_pc_q;

  assign req_acc  = mem.req && mem.gnt;
  assign keep_rsp = mem.rvalid && (drop_q == '0);
  assign push     = keep_rsp && !flush_i;
  assign pop      = fetch.valid && fetch.ready && !flush_i;

  assign push_entry = '{pc: resp_pc_q, inst: mem.rdata};

  ifq_fifo #(
    .WIDTH ($bits(fetch_entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .clear_i     (flush_i),
    .push_i      (push),
    .push_data_i (push_entry),
    .pop_i       (pop),
    .head_data_o (head_entry),
    .count_o     (count),
    .empty_o     (empty)
  );

  // An empty queue shows a NOP at the last address handed out.
  assign fetch.valid = !empty;
  assign fetch.inst  = empty ? INST_NOP  : head_entry.inst;
  assign fetch.pc    = empty ? last_pc_q : head_entry.pc;

  // Next-state for PCs and the in-flight / to-discard counters.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    last_pc_d  = last_pc_q;
    drop_d     = drop_q;
    outst_d    = outst_q + OW'(req_acc) - OW'(mem.rvalid);
    if (flush_i) begin
      // Everything still in flight after this edge belongs to the old stream.
      fetch_pc_d = word_align(flush_addr_i);
      resp_pc_d  = word_align(flush_addr_i);
      drop_d     = outst_d;
    end else begin
      if (req_acc)  fetch_pc_d = fetch_pc_q + WORD_BYTES;
      if (keep_rsp) resp_pc_d  = resp_pc_q + WORD_BYTES;
      else if (mem.rvalid) drop_d = drop_q - OW'(1);
      if (pop)      last_pc_d  = head_entry.pc;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_q <= START_ADDR;
      resp_pc_q  <= START_ADDR;
      last_pc_q  <= START_ADDR;
      outst_q    <= '0;
      drop_q     <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      last_pc_q  <= last_pc_d;
      outst_q    <= outst_d;
      drop_q     <= drop_d;
    end
  end

endmodule

// File: tb/tb_ifq.sv
// Directed bench for ifq: per-cycle vectors with hand-computed expectations,
// driven against a small in-order memory responder with settable latency.
module tb_ifq;
  import ifq_pkg::*;

  logic  clk = 1'b0;
  logic  rst_n = 1'b0;
  logic  flush = 1'b0;
  word_t flush_addr = '0;

  always #5 clk = ~clk;

  ifq_mem_if   mem_bus ();
  ifq_fetch_if fetch_bus ();

  ifq #(
    .DEPTH      (4),
    .MAX_OUTST  (2),
    .START_ADDR (32'h0000_0000)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush_i      (flush),
    .flush_addr_i (flush_addr),
    .mem          (mem_bus),
    .fetch        (fetch_bus)
  );

  typedef struct {
    bit    rst;
    int    lat;
    bit    gnt;
    bit    ready;
    bit    flush;
    word_t faddr;
    bit    e_req;
    word_t e_addr;
    bit    e_valid;
    word_t e_pc;
  } vec_t;

  typedef struct {
    word_t addr;
    int    due;
  } pend_t;

  pend_t pend[$];
  vec_t  vecs[$];
  int    n_checks = 0;
  int    n_fail   = 0;
  int    cyc      = 0;
  int    lat      = 1;

  function automatic word_t inst_of(input word_t a);
    return a ^ 32'h5A5A_0000;
  endfunction

  function automatic vec_t mk(input bit rst, input int l, input bit gnt, input bit ready,
                              input bit fl, input word_t fa, input bit e_req,
                              input word_t e_addr, input bit e_valid, input word_t e_pc);
    vec_t v;
    v.rst = rst; v.lat = l; v.gnt = gnt; v.ready = ready; v.flush = fl; v.faddr = fa;
    v.e_req = e_req; v.e_addr = e_addr; v.e_valid = e_valid; v.e_pc = e_pc;
    return v;
  endfunction

  task automatic check(input string name, input word_t act, input word_t exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    flush = 1'b0;
    mem_bus.gnt = 1'b0;
    mem_bus.rvalid = 1'b0;
    mem_bus.rdata = '0;
    fetch_bus.ready = 1'b0;
    pend.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    cyc = 0;
  endtask

  // One clock cycle: drive inputs, sample mid-cycle, then advance the responder.
  task automatic apply(input vec_t v, input string tag);
    logic  acc, rv;
    word_t a;
    if (v.rst) do_reset();
    lat = v.lat;
    flush = v.flush;
    flush_addr = v.faddr;
    fetch_bus.ready = v.ready;
    mem_bus.gnt = v.gnt;
    if (pend.size() > 0 && pend[0].due <= cyc) begin
      mem_bus.rvalid = 1'b1;
      mem_bus.rdata  = inst_of(pend[0].addr);
    end else begin
      mem_bus.rvalid = 1'b0;
      mem_bus.rdata  = '0;
    end
    #1;
    check({tag, ".req"}, word_t'(mem_bus.req), word_t'(v.e_req));
    if (v.e_req) check({tag, ".addr"}, mem_bus.addr, v.e_addr);
    check({tag, ".valid"}, word_t'(fetch_bus.valid), word_t'(v.e_valid));
    check({tag, ".pc"}, fetch_bus.pc, v.e_pc);
    check({tag, ".inst"}, fetch_bus.inst, v.e_valid ? inst_of(v.e_pc) : INST_NOP);
    acc = mem_bus.req && mem_bus.gnt;
    a   = mem_bus.addr;
    rv  = mem_bus.rvalid;
    @(posedge clk);
    if (rv) pend.delete(0);
    if (acc) pend.push_back('{addr: a, due: cyc + lat});
    cyc++;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    // Streaming: latency 1, always granting, always ready.
    vecs.push_back(mk(1, 1, 1, 1, 0, 0, 1, 32'h00, 0, 32'h00));
    vecs.push_back(mk(0, 1, 1, 1, 0, 0, 1, 32'h04, 0, 32'h00));
    vecs.push_back(mk(0, 1, 1, 1, 0, 0, 1, 32'h08, 1, 32'h00));
    vecs.push_back(mk(0, 1, 1, 1, 0, 0, 1, 32'h0C, 1, 32'h04));
    vecs.push_back(mk(0, 1, 1, 1, 0, 0, 1, 32'h10, 1, 32'h08));
    vecs.push_back(mk(0, 1, 1, 1, 0, 0, 1, 32'h14, 1, 32'h0C));
    // Consumer paused: fills to 4 entries, request stops, then drains in order.
    vecs.push_back(mk(1, 1, 1, 0, 0, 0, 1, 32'h00, 0, 32'h00));
    vecs.push_back(mk(0, 1, 1, 0, 0, 0, 1, 32'h04, 0, 32'h00));
    vecs.push_back(mk(0, 1, 1, 0, 0, 0, 1, 32'h08, 1, 32'h00));
    vecs.push_back(mk(0, 1, 1, 0, 0, 0, 1, 32'h0C, 1, 32'h00));
    vecs.push_back(mk(0, 1, 1, 0, 0, 0, 0, 32'h00, 1, 32'h00));
    vecs.push_back(mk(0, 1, 1, 0, 0, 0, 0, 32'h00, 1, 32'h00));
    vecs.push_back(mk(0, 1, 1, 1, 0, 0, 0, 32'h00, 1, 32'h00));
    vecs.push_back(mk(0, 1, 1, 1, 0, 0, 1, 32'h10, 1, 32'h04));
    vecs.push_back(mk(0, 1, 1, 1, 0, 0, 1, 32'h14, 1, 32'h08));
    vecs.push_back(mk(0, 1, 1, 1, 0, 0, 1, 32'h18, 1, 32'h0C));
    vecs.push_back(mk(0, 1, 1, 1, 0, 0, 1, 32'h1C, 1, 32'h10));
    vecs.push_back(mk(0, 1, 1, 1, 0, 0, 1, 32'h20, 1, 32'h14));
    // Latency 2: two in flight; flush to 0x203 alongside the 0x10 response.
    vecs.push_back(mk(1, 2, 1, 1, 0, 0, 1, 32'h00, 0, 32'h00));
    vecs.push_back(mk(0, 2, 1, 1, 0, 0, 1, 32'h04, 0, 32'h00));
    vecs.push_back(mk(0, 2, 1, 1, 0, 0, 0, 32'h00, 0, 32'h00));
    vecs.push_back(mk(0, 2, 1, 1, 0, 0, 1, 32'h08, 1, 32'h00));
    vecs.push_back(mk(0, 2, 1, 1, 0, 0, 1, 32'h0C, 1, 32'h04));
    vecs.push_back(mk(0, 2, 1, 1, 0, 0, 0, 32'h00, 0, 32'h04));
    vecs.push_back(mk(0, 2, 1, 1, 0, 0, 1, 32'h10, 1, 32'h08));
    vecs.push_back(mk(0, 2, 1, 1, 0, 0, 1, 32'h14, 1, 32'h0C));
    vecs.push_back(mk(0, 2, 1, 1, 1, 32'h203, 0, 32'h00, 0, 32'h0C));
    vecs.push_back(mk(0, 2, 1, 1, 0, 0, 1, 32'h200, 0, 32'h0C));
    vecs.push_back(mk(0, 2, 1, 1, 0, 0, 1, 32'h204, 0, 32'h0C));
    vecs.push_back(mk(0, 2, 1, 1, 0, 0, 0, 32'h00, 0, 32'h0C));
    vecs.push_back(mk(0, 2, 1, 1, 0, 0, 1, 32'h208, 1, 32'h200));
    vecs.push_back(mk(0, 2, 1, 1, 0, 0, 1, 32'h20C, 1, 32'h204));

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i], $sformatf("vec%0d", i));

    // Flush while a grant is offered: no grant counted, one old response dropped.
    apply(mk(1, 2, 1, 1, 0, 0, 1, 32'h000, 0, 32'h000), "gflush0");
    apply(mk(0, 2, 1, 1, 1, 32'h100, 0, 32'h000, 0, 32'h000), "gflush1");
    apply(mk(0, 2, 1, 1, 0, 0, 1, 32'h100, 0, 32'h000), "gflush2");
    apply(mk(0, 2, 1, 1, 0, 0, 1, 32'h104, 0, 32'h000), "gflush3");
    apply(mk(0, 2, 1, 1, 0, 0, 0, 32'h000, 0, 32'h000), "gflush4");
    apply(mk(0, 2, 1, 1, 0, 0, 1, 32'h108, 1, 32'h100), "gflush5");

    // Address wrap from the top of the address space.
    apply(mk(1, 1, 1, 1, 1, 32'hFFFF_FFFF, 0, 32'h0, 0, 32'h0), "wrap0");
    apply(mk(0, 1, 1, 1, 0, 0, 1, 32'hFFFF_FFFC, 0, 32'h0), "wrap1");
    apply(mk(0, 1, 1, 1, 0, 0, 1, 32'h0000_0000, 0, 32'h0), "wrap2");
    apply(mk(0, 1, 1, 1, 0, 0, 1, 32'h0000_0004, 1, 32'hFFFF_FFFC), "wrap3");
    apply(mk(0, 1, 1, 1, 0, 0, 1, 32'h0000_0008, 1, 32'h0000_0000), "wrap4");

    // Asynchronous reset with entries queued and a request in flight.
    apply(mk(1, 2, 1, 0, 0, 0, 1, 32'h00, 0, 32'h00), "arst0");
    apply(mk(0, 2, 1, 0, 0, 0, 1, 32'h04, 0, 32'h00), "arst1");
    apply(mk(0, 2, 1, 0, 0, 0, 0, 32'h00, 0, 32'h00), "arst2");
    apply(mk(0, 2, 1, 0, 0, 0, 1, 32'h08, 1, 32'h00), "arst3");
    apply(mk(0, 2, 1, 0, 0, 0, 1, 32'h0C, 1, 32'h00), "arst4");
    apply(mk(0, 2, 1, 0, 0, 0, 0, 32'h00, 1, 32'h00), "arst5");
    #2;
    rst_n = 1'b0;
    mem_bus.rvalid = 1'b0;
    #1;
    check("arst.valid", word_t'(fetch_bus.valid), 32'h0);
    check("arst.req", word_t'(mem_bus.req), 32'h0);
    check("arst.inst", fetch_bus.inst, INST_NOP);
    check("arst.pc", fetch_bus.pc, 32'h0);
    pend.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    cyc = 0;
    apply(mk(0, 2, 1, 0, 0, 0, 1, 32'h00, 0, 32'h00), "arst6");
    apply(mk(0, 2, 1, 0, 0, 0, 1, 32'h04, 0, 32'h00), "arst7");
    apply(mk(0, 2, 1, 0, 0, 0, 0, 32'h00, 0, 32'h00), "arst8");
    apply(mk(0, 2, 1, 0, 0, 0, 1, 32'h08, 1, 32'h00), "arst9");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
